// File: rtl/load_scheduler.sv
// load_scheduler: round-robin burst loader from one source stream into the FM and weight RAM write ports
module load_scheduler #(
  parameter int DATA_W    = 256,
  parameter int FM_ADDR_W = 10,
  parameter int WT_ADDR_W = 10,
  parameter int FM_BURST  = 18,
  parameter int WT_BURST  = 4,
  parameter int WT_STRIDE = 9,
  parameter int WT_HALF   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fm_req,
  input  logic [FM_ADDR_W-1:0] fm_base,
  input  logic                 wt_req,
  input  logic [WT_ADDR_W-1:0] wt_base,
  input  logic                 src_valid,
  input  logic [DATA_W-1:0]    src_data,
  output logic                 src_ready,
  output logic                 fm_wr_en,
  output logic [FM_ADDR_W-1:0] fm_wr_addr,
  output logic [DATA_W-1:0]    fm_wr_data,
  output logic                 wt_wr_en,
  output logic [WT_ADDR_W-1:0] wt_wr_addr,
  output logic [DATA_W-1:0]    wt_wr_data,
  output logic                 fm_done,
  output logic                 wt_done,
  output logic                 busy,
  output logic                 req_overflow
);
  typedef enum logic [1:0] {IDLE, FM_LOAD, WT_LOAD} state_t;
  localparam int CNT_W = (FM_ADDR_W > 6 ? FM_ADDR_W : 6) + 1;
  state_t state_q, state_d;
  logic fm_pend_q, fm_pend_d, wt_pend_q, wt_pend_d;
  logic last_wt_q, last_wt_d, ovf_q, ovf_d;
  logic [FM_ADDR_W-1:0] fm_base_q, fm_base_d;
  logic [WT_ADDR_W-1:0] wt_base_q, wt_base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fm_grant, wt_grant, fm_take, wt_take, hs, last_beat, fin;
  logic [31:0] wt_off;
  assign busy = state_q != IDLE;
  assign src_ready = busy;
  assign req_overflow = ovf_q;
  assign hs = src_valid & busy;
  assign fm_grant = (state_q == IDLE) & fm_pend_q & (!wt_pend_q | last_wt_q);
  assign wt_grant = (state_q == IDLE) & wt_pend_q & !fm_grant;
  assign last_beat = cnt_q == CNT_W'(state_q == WT_LOAD ? WT_BURST - 1 : FM_BURST - 1);
  assign fin = hs & last_beat;
  assign fm_take = fm_req & (!fm_pend_q | fm_grant);
  assign wt_take = wt_req & (!wt_pend_q | wt_grant);
  assign wt_off = (cnt_q[0] ? 32'(WT_STRIDE) : 32'd0) + 32'(cnt_q >> 1) * 32'(WT_HALF);
  // next-state: request latching, round-robin grant, beat counting
  always_comb begin
    fm_pend_d = fm_take | (fm_pend_q & !fm_grant);
    wt_pend_d = wt_take | (wt_pend_q & !wt_grant);
    fm_base_d = fm_take ? fm_base : fm_base_q;
    wt_base_d = wt_take ? wt_base : wt_base_q;
    ovf_d = ovf_q | (fm_req & !fm_take) | (wt_req & !wt_take);
    last_wt_d = fm_grant ? 1'b0 : wt_grant ? 1'b1 : last_wt_q;
    state_d = fm_grant ? FM_LOAD : wt_grant ? WT_LOAD : fin ? IDLE : state_q;
    cnt_d = (fm_grant | wt_grant | fin) ? '0 : hs ? cnt_q + 1'b1 : cnt_q;
  end
  // state register plus registered write ports and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fm_pend_q <= 1'b0;
      wt_pend_q <= 1'b0;
      fm_base_q <= '0;
      wt_base_q <= '0;
      last_wt_q <= 1'b1;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      fm_wr_en <= 1'b0;
      fm_wr_addr <= '0;
      fm_wr_data <= '0;
      wt_wr_en <= 1'b0;
      wt_wr_addr <= '0;
      wt_wr_data <= '0;
      fm_done <= 1'b0;
      wt_done <= 1'b0;
    end else begin
      state_q <= state_d;
      fm_pend_q <= fm_pend_d;
      wt_pend_q <= wt_pend_d;
      fm_base_q <= fm_base_d;
      wt_base_q <= wt_base_d;
      last_wt_q <= last_wt_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      fm_wr_en <= hs & (state_q == FM_LOAD);
      wt_wr_en <= hs & (state_q == WT_LOAD);
      fm_done <= fin & (state_q == FM_LOAD);
      wt_done <= fin & (state_q == WT_LOAD);
      if (hs && state_q == FM_LOAD) begin
        fm_wr_addr <= fm_base_q + FM_ADDR_W'(cnt_q);
        fm_wr_data <= src_data;
      end
      if (hs && state_q == WT_LOAD) begin
        wt_wr_addr <= wt_base_q + WT_ADDR_W'(wt_off);
        wt_wr_data <= src_data;
      end
    end
  end
endmodule
